// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one external memory port between the Thumb core's instruction
//   fetch (IF) and the MEM-stage data access. A three-state grant FSM
//   (IDLE -> ACC -> RESP) arbitrates with data priority. A fetch
//   anti-starvation guard forces an IF grant after STARVE_LIMIT data grants
//   in a row while IF was waiting. A bus-timeout watchdog aborts an access
//   that never sees MACK.
//
// Optional feature (compile-time macro ARB_ALIGN_CHK_EN):
//   When defined, a misaligned data access is rejected without touching the
//   memory port. D_DONE and ERR pulse one cycle after the grant. When the
//   macro is undefined, no alignment check is made and D_ADDR goes to MADDR
//   unmodified.
//
// Parameters:
//   STARVE_LIMIT  consecutive data grants with I_REQ pending before IF wins
//                 the next arbitration (1..15)
//   TIMEOUT_CYC   ACC cycles without MACK before the access is aborted;
//                 0 disables the watchdog
//
// Ports:
//   CLK, RESET_N                  clock (rising edge), async active-low reset
//   I_REQ, I_ADDR                 fetch request / byte address
//   I_RDATA, I_DONE               fetched word / one-cycle completion pulse
//   D_REQ, D_ADDR, D_RW, D_SIZE,
//   D_WDATA                       data request, address, direction, size,
//                                 store data
//   D_RDATA, D_DONE               load data / one-cycle completion pulse
//   ERR                           pulses with DONE when an access is aborted
//   STALL                         combinational D_REQ & ~D_DONE
//   MREQ, MADDR, MRW, MSIZE,
//   MWDATA                        memory-side request and control
//   MRDATA, MACK                  memory read data / one-cycle acknowledge
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned TIMEOUT_CYC  = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_RDATA,
    output logic        I_DONE,
    input  logic        D_REQ,
    input  logic [31:0] D_ADDR,
    input  logic        D_RW,
    input  logic [1:0]  D_SIZE,
    input  logic [31:0] D_WDATA,
    output logic [31:0] D_RDATA,
    output logic        D_DONE,
    output logic        ERR,
    output logic        STALL,
    output logic        MREQ,
    output logic [31:0] MADDR,
    output logic        MRW,
    output logic [1:0]  MSIZE,
    output logic [31:0] MWDATA,
    input  logic [31:0] MRDATA,
    input  logic        MACK
);

    // Saturation point of the starvation counter and last legal count of the
    // watchdog. The watchdog compare is only enabled when TIMEOUT_CYC != 0, so
    // the guard on the subtraction just keeps the constant well defined.
    localparam int unsigned STARVE_I   = STARVE_LIMIT;
    localparam logic [3:0]  STARVE_MAX = STARVE_I[3:0];
    localparam int unsigned TMO_LAST_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [7:0]  TMO_LAST   = TMO_LAST_I[7:0];
    localparam bit          TMO_EN     = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        owner_i;
    logic [3:0]  starve_cnt;
    logic [7:0]  tmo_cnt;

    logic        pick_i;
    logic        pick_d;
    logic        grant_i;
    logic        grant_d;
    logic        acc_ack;
    logic        acc_abort;
    logic        d_misalign;
    logic [1:0]  d_size_eff;

    // IF wins when it is the only requester, or when data has starved it for
    // STARVE_LIMIT grants in a row. Otherwise a data request takes the port.
    assign pick_i = I_REQ & (~D_REQ | (starve_cnt == STARVE_MAX));
    assign pick_d = D_REQ & ~pick_i;

    // Size code 11 is issued to memory as a plain word access.
    assign d_size_eff = (D_SIZE == 2'b11) ? 2'b10 : D_SIZE;

    // The pipeline is held while a data access is outstanding. It is released
    // in the cycle its DONE pulse is visible.
    assign STALL = D_REQ & ~D_DONE;

`ifdef ARB_ALIGN_CHK_EN
    // A halfword needs bit 0 clear. A word (or size code 11) needs bits 1:0
    // clear. Bytes are always aligned.
    always_comb begin
        d_misalign = 1'b0;
        case (D_SIZE)
            2'b00:   d_misalign = 1'b0;
            2'b01:   d_misalign = D_ADDR[0];
            default: d_misalign = |D_ADDR[1:0];
        endcase
    end
`else
    assign d_misalign = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle event strobes. The strobes tell the
    // datapath block below what happens at the coming edge. A rejected
    // misaligned data grant skips ACC and goes straight to RESP.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        acc_ack    = 1'b0;
        acc_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_i) begin
                    grant_i    = 1'b1;
                    state_next = ACC;
                end else if (pick_d) begin
                    grant_d    = 1'b1;
                    state_next = d_misalign ? RESP : ACC;
                end
            end
            ACC: begin
                if (MACK) begin
                    acc_ack    = 1'b1;
                    state_next = RESP;
                end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                    acc_abort  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. DONE and ERR default low every cycle,
    // so they form exact one-cycle pulses. That pulse lines up with RESP, or
    // with the single cycle after a rejected misaligned grant. Read data
    // registers change only on a completed or aborted read, so they hold
    // across writes and idle time.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_i    <= 1'b0;
            starve_cnt <= 4'd0;
            tmo_cnt    <= 8'd0;
            MREQ       <= 1'b0;
            MADDR      <= 32'd0;
            MRW        <= 1'b0;
            MSIZE      <= 2'b00;
            MWDATA     <= 32'd0;
            I_RDATA    <= 32'd0;
            D_RDATA    <= 32'd0;
            I_DONE     <= 1'b0;
            D_DONE     <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            I_DONE <= 1'b0;
            D_DONE <= 1'b0;
            ERR    <= 1'b0;

            if (state == ACC) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if (grant_i) begin
                owner_i    <= 1'b1;
                starve_cnt <= 4'd0;
                tmo_cnt    <= 8'd0;
                MREQ       <= 1'b1;
                MADDR      <= {I_ADDR[31:2], 2'b00};
                MRW        <= 1'b0;
                MSIZE      <= 2'b10;
                MWDATA     <= 32'd0;
            end

            if (grant_d) begin
                owner_i <= 1'b0;
                tmo_cnt <= 8'd0;
                if (I_REQ && (starve_cnt != STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
                if (d_misalign) begin
                    D_DONE <= 1'b1;
                    ERR    <= 1'b1;
                end else begin
                    MREQ   <= 1'b1;
                    MADDR  <= D_ADDR;
                    MRW    <= D_RW;
                    MSIZE  <= d_size_eff;
                    MWDATA <= D_WDATA;
                end
            end

            // An aborted read returns zero so the requester never consumes
            // stale data alongside ERR.
            if (acc_ack || acc_abort) begin
                MREQ <= 1'b0;
                ERR  <= acc_abort;
                if (owner_i) begin
                    I_DONE <= 1'b1;
                    if (!MRW) begin
                        I_RDATA <= acc_abort ? 32'd0 : MRDATA;
                    end
                end else begin
                    D_DONE <= 1'b1;
                    if (!MRW) begin
                        D_RDATA <= acc_abort ? 32'd0 : MRDATA;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Self-checking bench for mem_port_arbiter with default parameters
//   (STARVE_LIMIT = 3, TIMEOUT_CYC = 16). A memory responder acknowledges
//   after a programmable number of ACC cycles. Scenario tasks push expected
//   completions to a scoreboard queue and pop them when DONE appears. The
//   alignment scenario runs only when ARB_ALIGN_CHK_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        CLK;
    logic        RESET_N;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic [31:0] I_RDATA;
    logic        I_DONE;
    logic        D_REQ;
    logic [31:0] D_ADDR;
    logic        D_RW;
    logic [1:0]  D_SIZE;
    logic [31:0] D_WDATA;
    logic [31:0] D_RDATA;
    logic        D_DONE;
    logic        ERR;
    logic        STALL;
    logic        MREQ;
    logic [31:0] MADDR;
    logic        MRW;
    logic [1:0]  MSIZE;
    logic [31:0] MWDATA;
    logic [31:0] MRDATA;
    logic        MACK;

    int errors = 0;
    int checks = 0;

    // Memory responder controls and grant capture.
    logic [31:0] mem_rdata  = 32'd0;
    int          mack_delay = 0;
    bit          mack_never = 1'b0;
    bit          stray_mack = 1'b0;
    int          acc_len    = 0;
    int          last_len   = 0;
    int          grant_cnt  = 0;
    logic [31:0] cap_maddr  = 32'd0;
    logic [31:0] cap_mwdata = 32'd0;
    logic        cap_mrw    = 1'b0;
    logic [1:0]  cap_msize  = 2'b00;

    typedef struct {
        bit          port_i;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    mem_port_arbiter dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .I_REQ   (I_REQ),
        .I_ADDR  (I_ADDR),
        .I_RDATA (I_RDATA),
        .I_DONE  (I_DONE),
        .D_REQ   (D_REQ),
        .D_ADDR  (D_ADDR),
        .D_RW    (D_RW),
        .D_SIZE  (D_SIZE),
        .D_WDATA (D_WDATA),
        .D_RDATA (D_RDATA),
        .D_DONE  (D_DONE),
        .ERR     (ERR),
        .STALL   (STALL),
        .MREQ    (MREQ),
        .MADDR   (MADDR),
        .MRW     (MRW),
        .MSIZE   (MSIZE),
        .MWDATA  (MWDATA),
        .MRDATA  (MRDATA),
        .MACK    (MACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory responder: looks at the registered request just after each edge.
    // It captures the command in the first ACC cycle and raises MACK in ACC
    // cycle mack_delay+1. Optionally it drives a stray MACK while idle.
    initial begin
        MACK   = 1'b0;
        MRDATA = 32'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (MREQ) begin
                acc_len++;
                last_len = acc_len;
                if (acc_len == 1) begin
                    grant_cnt++;
                    cap_maddr  = MADDR;
                    cap_mrw    = MRW;
                    cap_msize  = MSIZE;
                    cap_mwdata = MWDATA;
                end
                if (!mack_never && acc_len > mack_delay) begin
                    MACK   = 1'b1;
                    MRDATA = mem_rdata;
                end else begin
                    MACK   = 1'b0;
                    MRDATA = 32'h5A5A5A5A;
                end
            end else begin
                acc_len = 0;
                MACK    = stray_mack;
                MRDATA  = 32'hDEADDEAD;
            end
        end
    end

    // Waits (bounded) for any DONE pulse, sampling on falling edges.
    task automatic wait_done(input int budget, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge CLK);
            cyc++;
            if (I_DONE || D_DONE) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        I_REQ   = 1'b0;
        I_ADDR  = 32'd0;
        D_REQ   = 1'b0;
        D_ADDR  = 32'd0;
        D_RW    = 1'b0;
        D_SIZE  = 2'b00;
        D_WDATA = 32'd0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({MREQ, MRW, I_DONE, D_DONE, ERR, STALL} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {MREQ, MRW, I_DONE, D_DONE, ERR, STALL});
        end
        checks++;
        if ({MADDR, MWDATA, I_RDATA, D_RDATA, MSIZE} !== 130'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: MADDR=%h MWDATA=%h I_RDATA=%h D_RDATA=%h MSIZE=%b expected all 0",
                     MADDR, MWDATA, I_RDATA, D_RDATA, MSIZE);
        end
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_fetch();
        exp_t e;
        bit   ok;
        int   cyc;
        mack_delay = 0;
        mem_rdata  = 32'h4770B500;
        exp_q.push_back('{1'b1, 32'h4770B500, 1'b0, 2});
        I_ADDR = 32'h00000106;
        I_REQ  = 1'b1;
        wait_done(10, ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc !== e.lat) begin
            errors++;
            $display("[TB] FAIL fetch_latency: got %0d cycles (done=%0d) expected %0d", cyc, ok, e.lat);
        end
        checks++;
        if ({I_DONE, D_DONE, ERR} !== {e.port_i, !e.port_i, e.err}) begin
            errors++;
            $display("[TB] FAIL fetch_flags: I_DONE/D_DONE/ERR=%b expected %b",
                     {I_DONE, D_DONE, ERR}, {e.port_i, !e.port_i, e.err});
        end
        checks++;
        if (I_RDATA !== e.rdata) begin
            errors++;
            $display("[TB] FAIL fetch_rdata: got %h expected %h", I_RDATA, e.rdata);
        end
        checks++;
        if ({cap_maddr, cap_msize, cap_mrw} !== {32'h00000104, 2'b10, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fetch_cmd: MADDR=%h MSIZE=%b MRW=%b expected 00000104 10 0",
                     cap_maddr, cap_msize, cap_mrw);
        end
        I_REQ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_store();
        exp_t e;
        bit   ok;
        int   cyc;
        // Load first so D_RDATA has a known value for the store to preserve.
        mack_delay = 0;
        mem_rdata  = 32'hCAFEF00D;
        exp_q.push_back('{1'b0, 32'hCAFEF00D, 1'b0, 2});
        D_ADDR = 32'h00001000;
        D_RW   = 1'b0;
        D_SIZE = 2'b10;
        D_REQ  = 1'b1;
        wait_done(10, ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || D_DONE !== 1'b1 || D_RDATA !== e.rdata) begin
            errors++;
            $display("[TB] FAIL load_rdata: done=%0d D_DONE=%b D_RDATA=%h expected %h",
                     ok, D_DONE, D_RDATA, e.rdata);
        end
        D_REQ = 1'b0;
        @(negedge CLK);

        mack_delay = 4;
        mem_rdata  = 32'h11111111;
        exp_q.push_back('{1'b0, 32'hCAFEF00D, 1'b0, 6});
        D_ADDR  = 32'h00002000;
        D_RW    = 1'b1;
        D_SIZE  = 2'b01;
        D_WDATA = 32'h0000BEEF;
        D_REQ   = 1'b1;
        wait_done(20, ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc !== e.lat) begin
            errors++;
            $display("[TB] FAIL store_latency: got %0d cycles (done=%0d) expected %0d", cyc, ok, e.lat);
        end
        checks++;
        if ({cap_maddr, cap_mrw, cap_msize, cap_mwdata} !== {32'h00002000, 1'b1, 2'b01, 32'h0000BEEF}) begin
            errors++;
            $display("[TB] FAIL store_cmd: MADDR=%h MRW=%b MSIZE=%b MWDATA=%h expected 00002000 1 01 0000beef",
                     cap_maddr, cap_mrw, cap_msize, cap_mwdata);
        end
        checks++;
        if ({D_DONE, ERR, STALL} !== {1'b1, e.err, 1'b0} || D_RDATA !== e.rdata) begin
            errors++;
            $display("[TB] FAIL store_done: D_DONE/ERR/STALL=%b D_RDATA=%h expected 100 %h",
                     {D_DONE, ERR, STALL}, D_RDATA, e.rdata);
        end
        D_REQ = 1'b0;
        D_RW  = 1'b0;
        mack_delay = 0;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok;
        int   cyc;
        mack_never = 1'b1;
        exp_q.push_back('{1'b0, 32'h00000000, 1'b1, 17});
        D_ADDR = 32'h00001004;
        D_RW   = 1'b0;
        D_SIZE = 2'b10;
        D_REQ  = 1'b1;
        wait_done(40, ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc !== e.lat) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d cycles (done=%0d) expected %0d", cyc, ok, e.lat);
        end
        checks++;
        if ({D_DONE, ERR, MREQ} !== {1'b1, e.err, 1'b0} || D_RDATA !== e.rdata) begin
            errors++;
            $display("[TB] FAIL timeout_flags: D_DONE/ERR/MREQ=%b D_RDATA=%h expected 110 %h",
                     {D_DONE, ERR, MREQ}, D_RDATA, e.rdata);
        end
        checks++;
        if (last_len !== 16) begin
            errors++;
            $display("[TB] FAIL timeout_acc_len: MREQ high %0d cycles expected 16", last_len);
        end
        D_REQ = 1'b0;
        mack_never = 1'b0;
        @(negedge CLK);

        mem_rdata = 32'h12345678;
        exp_q.push_back('{1'b1, 32'h12345678, 1'b0, 2});
        I_ADDR = 32'h00000200;
        I_REQ  = 1'b1;
        wait_done(10, ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc !== e.lat || {I_DONE, ERR} !== {1'b1, e.err} || I_RDATA !== e.rdata) begin
            errors++;
            $display("[TB] FAIL after_timeout_fetch: cyc=%0d I_DONE/ERR=%b I_RDATA=%h expected %0d 10 %h",
                     cyc, {I_DONE, ERR}, I_RDATA, e.lat, e.rdata);
        end
        I_REQ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_starvation();
        exp_t e;
        int   done_cnt  = 0;
        int   order_bad = 0;
        int   stall_bad = 0;
        int   budget    = 0;
        mack_delay = 0;
        mem_rdata  = 32'h0BADF00D;
        // Expected grant order with STARVE_LIMIT = 3: D, D, D, I, D, D, D, I.
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back('{(k % 4) == 3, 32'h0BADF00D, 1'b0, 0});
        end
        I_ADDR = 32'h00000400;
        D_ADDR = 32'h00003000;
        D_RW   = 1'b0;
        D_SIZE = 2'b10;
        I_REQ  = 1'b1;
        D_REQ  = 1'b1;
        while (done_cnt < 8 && budget < 40) begin
            @(negedge CLK);
            budget++;
            if (I_DONE || D_DONE) begin
                e = exp_q.pop_front();
                done_cnt++;
                if ({I_DONE, D_DONE, ERR} !== {e.port_i, !e.port_i, 1'b0} ||
                    STALL !== e.port_i) begin
                    order_bad++;
                    $display("[TB] FAIL starve_grant_%0d: I_DONE/D_DONE/ERR/STALL=%b expected %b",
                             done_cnt, {I_DONE, D_DONE, ERR, STALL},
                             {e.port_i, !e.port_i, 1'b0, e.port_i});
                end
            end else if (STALL !== 1'b1) begin
                stall_bad++;
            end
        end
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        checks++;
        if (done_cnt !== 8 || order_bad !== 0) begin
            errors++;
            $display("[TB] FAIL starve_order: %0d completions, %0d wrong, expected 8 and 0",
                     done_cnt, order_bad);
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("[TB] FAIL starve_stall: STALL low in %0d non-done cycles expected 0", stall_bad);
        end
        checks++;
        if (I_RDATA !== 32'h0BADF00D || D_RDATA !== 32'h0BADF00D) begin
            errors++;
            $display("[TB] FAIL starve_rdata: I_RDATA=%h D_RDATA=%h expected 0badf00d",
                     I_RDATA, D_RDATA);
        end
        exp_q.delete();
        @(negedge CLK);
    endtask

    task automatic test_stray_mack();
        int seen_done = 0;
        stray_mack = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            if (I_DONE || D_DONE || MREQ) seen_done++;
        end
        stray_mack = 1'b0;
        @(negedge CLK);
        checks++;
        if (seen_done !== 0 || I_RDATA !== 32'h0BADF00D || D_RDATA !== 32'h0BADF00D) begin
            errors++;
            $display("[TB] FAIL stray_mack: activity=%0d I_RDATA=%h D_RDATA=%h expected 0 0badf00d 0badf00d",
                     seen_done, I_RDATA, D_RDATA);
        end
    endtask

`ifdef ARB_ALIGN_CHK_EN
    task automatic test_align();
        bit ok;
        int cyc;
        int grants_before;
        grants_before = grant_cnt;
        D_ADDR = 32'h00003002;
        D_RW   = 1'b0;
        D_SIZE = 2'b10;
        D_REQ  = 1'b1;
        wait_done(10, ok, cyc);
        checks++;
        if (!ok || cyc !== 1 || {D_DONE, ERR, MREQ} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL align_reject: cyc=%0d D_DONE/ERR/MREQ=%b expected 1 110", cyc, {D_DONE, ERR, MREQ});
        end
        D_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (grant_cnt !== grants_before || D_RDATA !== 32'h0BADF00D) begin
            errors++;
            $display("[TB] FAIL align_no_access: grants=%0d D_RDATA=%h expected %0d 0badf00d",
                     grant_cnt, D_RDATA, grants_before);
        end
    endtask
`endif

    task automatic test_reset_mid_access();
        exp_t e;
        bit   ok;
        int   cyc;
        mack_never = 1'b1;
        I_ADDR = 32'h00000500;
        I_REQ  = 1'b1;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({MREQ, I_DONE, D_DONE, ERR} !== 4'b0 || MADDR !== 32'd0 || I_RDATA !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: MREQ/I_DONE/D_DONE/ERR=%b MADDR=%h I_RDATA=%h expected all 0",
                     {MREQ, I_DONE, D_DONE, ERR}, MADDR, I_RDATA);
        end
        @(negedge CLK);
        mack_never = 1'b0;
        mem_rdata  = 32'hA5A50001;
        exp_q.push_back('{1'b1, 32'hA5A50001, 1'b0, 2});
        RESET_N = 1'b1;
        wait_done(10, ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc !== e.lat || I_DONE !== 1'b1 || I_RDATA !== e.rdata || cap_maddr !== 32'h00000500) begin
            errors++;
            $display("[TB] FAIL reset_rearb: cyc=%0d I_DONE=%b I_RDATA=%h MADDR=%h expected %0d 1 %h 00000500",
                     cyc, I_DONE, I_RDATA, cap_maddr, e.lat, e.rdata);
        end
        I_REQ = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_timeout();
        test_starvation();
        test_stray_mack();
`ifdef ARB_ALIGN_CHK_EN
        test_align();
`endif
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the Thumb core's instruction fetch (IF) and the MEM-stage data access.
- Runs a grant FSM with data-priority arbitration, a fetch anti-starvation guard and a bus-timeout watchdog.
- Sits between IF/MEM and the single memory interface; STALL drives the pipeline-register enables.

Parameters:
- STARVE_LIMIT, 3: consecutive data grants while I_REQ is pending, after which IF wins the next arbitration (1..15).
- TIMEOUT_CYC, 16: ACC cycles without MACK before the access is aborted; 0 disables the watchdog (8-bit counter).

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- I_REQ  in  1  fetch request, level; held with I_ADDR stable until I_DONE.
- I_ADDR  in  32  fetch byte address.
- I_RDATA  out  32  fetched word.
- I_DONE  out  1  one-cycle completion pulse for fetch.
- D_REQ  in  1  data request, level; held with the D_* inputs stable until D_DONE.
- D_ADDR  in  32  data byte address.
- D_RW  in  1  1 = write (store), 0 = read (load).
- D_SIZE  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- D_WDATA  in  32  store data.
- D_RDATA  out  32  load data.
- D_DONE  out  1  one-cycle completion pulse for data.
- ERR  out  1  pulses with DONE when an access is aborted.
- STALL  out  1  combinational: D_REQ & ~D_DONE.
- MREQ  out  1  memory request.
- MADDR  out  32  memory address.
- MRW  out  1  memory write strobe (1 = write).
- MSIZE  out  2  memory access size.
- MWDATA  out  32  memory write data.
- MRDATA  in  32  memory read data, valid when MACK = 1.
- MACK  in  1  memory acknowledge, one cycle.

Behaviour:
- Reset (async, RESET_N = 0): state IDLE; all registered outputs 0; starve_cnt and tmo_cnt 0. Reset mid-access abandons the access with no DONE.
- All outputs registered except STALL.

FSM states: IDLE, ACC, RESP.
- IDLE, neither REQ high: stay in IDLE.
- IDLE, D_REQ only: grant D.
- IDLE, I_REQ only: grant I.
- IDLE, both high: grant D unless starve_cnt == STARVE_LIMIT, then grant I.
- On any grant: load MADDR/MRW/MSIZE/MWDATA, set MREQ = 1, go to ACC.
- I grant drives MADDR = {I_ADDR[31:2], 2'b00}, MSIZE = 10, MRW = 0.
- starve_cnt increments on a D grant while I_REQ = 1 and saturates at STARVE_LIMIT; it clears on any I grant.

ACC:
- MREQ and the address/control outputs stay stable.
- MACK may arrive in the first ACC cycle.
- On MACK: for a read, capture MRDATA into I_RDATA or D_RDATA; clear MREQ; go to RESP.
- If TIMEOUT_CYC != 0 and tmo_cnt reaches TIMEOUT_CYC-1 without MACK: clear MREQ, set ERR, write 0 into the granted port's RDATA on a read, go to RESP.
- tmo_cnt counts ACC cycles and clears on entry to ACC.

RESP (exactly one cycle):
- The granted port's DONE = 1; ERR = 1 only for an aborted access.
- No requests are sampled; the next state is IDLE.
- The requester drops or renews REQ at the edge ending DONE.

Timing and data rules:
- Latency: REQ sampled in IDLE at cycle c gives DONE at c+2 minimum (MACK in the first ACC cycle).
- Back-to-back accesses from the same requester occur every 3 cycles minimum.
- A write leaves D_RDATA unchanged.
- I_RDATA and D_RDATA hold their values until the next completed read on that port.
- A MACK seen outside ACC is ignored.

Optional Feature:
- Macro: ARB_ALIGN_CHK_EN.
- Defined: a data grant with a misaligned address goes IDLE to RESP directly, with no MREQ, and pulses D_DONE and ERR. Misaligned means halfword with D_ADDR[0] = 1, or word/11 with D_ADDR[1:0] != 0. D_RDATA is unchanged. starve_cnt updates as for a normal grant.
- Undefined: no check; D_ADDR is passed to MADDR unmodified.

Test Plan:
- I_REQ = 1, I_ADDR = 0x00000106, MACK in the first ACC cycle with MRDATA = 0x4770B500 -> MADDR = 0x00000104, MSIZE = 10; I_DONE at c+2; I_RDATA = 0x4770B500; ERR = 0.
- I_REQ and D_REQ both high continuously, STARVE_LIMIT = 3, MACK immediate -> grant order D, D, D, I, D, D, D, I; STALL high except during D_DONE cycles.
- D store, D_ADDR = 0x2000, D_SIZE = 01, D_WDATA = 0x0000BEEF, MACK after 4 ACC cycles -> MRW = 1, MSIZE = 01, MWDATA = 0x0000BEEF; D_DONE 6 cycles after the request is sampled; D_RDATA unchanged.
- Timeout: TIMEOUT_CYC = 16, D load with MACK never asserted -> MREQ drops after 16 ACC cycles; D_DONE = 1 and ERR = 1 together; D_RDATA = 0; a later I_REQ is served normally.
- RESET_N driven low in the 2nd ACC cycle -> outputs 0 immediately (asynchronous), no DONE; after release, a pending I_REQ is re-arbitrated from IDLE.
- With ARB_ALIGN_CHK_EN, D load at D_ADDR = 0x3002, D_SIZE = 10 -> no MREQ; D_DONE and ERR at c+1.
